// File: rtl/mips16_multicycle_ctrl_pkg.sv
// Shared codes for the 16-bit multi-cycle CPU control: FSM states, opcodes,
// ALU control values and the decoded-select bundle.
package mips16_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_ctl;
  } sel_t;

  typedef struct packed {
    logic legal;
    sel_t sel;
  } dec_t;

  localparam sel_t SEL_RESET = '{reg_dst: 1'b0, alu_src: 1'b0, alu_ctl: ALU_ADD};

  function automatic dec_t rtype(input logic [2:0] ctl);
    return '{legal: 1'b1, sel: '{reg_dst: 1'b1, alu_src: 1'b0, alu_ctl: ctl}};
  endfunction

endpackage

// File: rtl/mips16_multicycle_ctrl_if.sv
// Control-unit bundle: instruction-side inputs plus strobes, selects and status.
// master = control unit, slave = datapath / observer.
interface mips16_multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             imem_ready;
  logic [3:0]       opcode;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src;
  logic [2:0]       alu_ctl;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  imem_ready, opcode,
    output ir_write, pc_write, reg_write, reg_dst, alu_src, alu_ctl,
           state, halted, retired
  );

  modport slave (
    output imem_ready, opcode,
    input  ir_write, pc_write, reg_write, reg_dst, alu_src, alu_ctl,
           state, halted, retired
  );
endinterface

// File: rtl/mips16_multicycle_ctrl_decoder.sv
// Combinational opcode decoder: legality plus reg_dst/alu_src/alu_ctl.
// Shared with the single-cycle CPU variant, so it holds no state.
module mips16_multicycle_ctrl_decoder
  import mips16_multicycle_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '{legal: 1'b0, sel: SEL_RESET};
    case (opcode)
      OP_ADD:  dec = rtype(ALU_ADD);
      OP_SUB:  dec = rtype(ALU_SUB);
      OP_AND:  dec = rtype(ALU_AND);
      OP_OR:   dec = rtype(ALU_OR);
      OP_SLT:  dec = rtype(ALU_SLT);
      OP_ADDI: dec = '{legal: 1'b1, sel: '{reg_dst: 1'b0, alu_src: 1'b1, alu_ctl: ALU_ADD}};
      default: dec = '{legal: 1'b0, sel: SEL_RESET};
    endcase
  end

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/WB (+ sticky HALT), registered
// datapath selects and a wrapping retired-instruction counter.
module mips16_multicycle_ctrl
  import mips16_multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  mips16_multicycle_ctrl_if.master   bus
);

  state_e           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  dec_t             dec;

  mips16_multicycle_ctrl_decoder u_dec (
    .opcode (bus.opcode),
    .dec    (dec)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      sel_q     <= SEL_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    retired_d     = retired_q;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.reg_write = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // Mealy strobes: IR and PC load in the same cycle the memory is ready.
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.legal) begin
          sel_d   = dec.sel;
          state_d = ST_EXEC;
        end else if (ILLEGAL_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        bus.reg_write = 1'b1;
        retired_d     = retired_q + 1'b1;
        state_d       = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  assign bus.reg_dst = sel_q.reg_dst;
  assign bus.alu_src = sel_q.alu_src;
  assign bus.alu_ctl = sel_q.alu_ctl;
  assign bus.state   = state_q;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// Bench: two controller instances (halting 16-bit counter, non-halting 2-bit
// counter) driven by directed and random instruction streams against a model.
module tb_mips16_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       rst_a_n = 1'b0;
  logic       rst_b_n = 1'b0;
  logic       imem_ready = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       sel_b = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mips16_multicycle_ctrl_if #(.CNT_W(16)) bus_a ();
  mips16_multicycle_ctrl_if #(.CNT_W(2))  bus_b ();

  assign bus_a.imem_ready = imem_ready;
  assign bus_a.opcode     = opcode;
  assign bus_b.imem_ready = imem_ready;
  assign bus_b.opcode     = opcode;

  mips16_multicycle_ctrl #(.CNT_W(16), .ILLEGAL_HALT(1'b1)) dut_a (
    .clock   (clock),
    .reset_n (rst_a_n),
    .bus     (bus_a)
  );

  mips16_multicycle_ctrl #(.CNT_W(2), .ILLEGAL_HALT(1'b0)) dut_b (
    .clock   (clock),
    .reset_n (rst_b_n),
    .bus     (bus_b)
  );

  logic [2:0]  obs_state, obs_ac;
  logic        obs_ir, obs_pc, obs_rw, obs_rd, obs_as, obs_halt;
  logic [15:0] obs_ret;

  always_comb begin
    obs_state = sel_b ? bus_b.state     : bus_a.state;
    obs_ir    = sel_b ? bus_b.ir_write  : bus_a.ir_write;
    obs_pc    = sel_b ? bus_b.pc_write  : bus_a.pc_write;
    obs_rw    = sel_b ? bus_b.reg_write : bus_a.reg_write;
    obs_rd    = sel_b ? bus_b.reg_dst   : bus_a.reg_dst;
    obs_as    = sel_b ? bus_b.alu_src   : bus_a.alu_src;
    obs_ac    = sel_b ? bus_b.alu_ctl   : bus_a.alu_ctl;
    obs_halt  = sel_b ? bus_b.halted    : bus_a.halted;
    obs_ret   = sel_b ? 16'(bus_b.retired) : bus_a.retired;
  end

  // Reference model: architectural view of one instruction at a time.
  logic        m_rd, m_as, m_halt;
  logic [2:0]  m_ac;
  logic [15:0] m_ret;

  logic [3:0] legal_ops [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7};

  // Returns {legal, reg_dst, alu_src, alu_ctl} from the opcode table.
  function automatic logic [5:0] ref_decode(input logic [3:0] op);
    case (op)
      4'h0: return 6'b1_1_0_010;
      4'h1: return 6'b1_1_0_110;
      4'h2: return 6'b1_1_0_000;
      4'h3: return 6'b1_1_0_001;
      4'h4: return 6'b1_1_0_111;
      4'h7: return 6'b1_0_1_010;
      default: return 6'b0_0_0_000;
    endcase
  endfunction

  function automatic logic [15:0] cnt_mask();
    return sel_b ? 16'h0003 : 16'hFFFF;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [2:0] es, input logic eir, input logic erw);
    chk("state",     16'(obs_state), 16'(es));
    chk("ir_write",  16'(obs_ir),    16'(eir));
    chk("pc_write",  16'(obs_pc),    16'(eir));
    chk("reg_write", 16'(obs_rw),    16'(erw));
    chk("reg_dst",   16'(obs_rd),    16'(m_rd));
    chk("alu_src",   16'(obs_as),    16'(m_as));
    chk("alu_ctl",   16'(obs_ac),    16'(m_ac));
    chk("halted",    16'(obs_halt),  16'(m_halt));
    chk("retired",   obs_ret,        m_ret);
  endtask

  // Entered and left at posedge+1; outputs sampled at the falling edge.
  task automatic step(input logic rdy, input logic [3:0] op,
                      input logic [2:0] es, input logic eir, input logic erw);
    imem_ready = rdy;
    opcode     = op;
    @(negedge clock);
    check_all(es, eir, erw);
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_rd = 1'b0; m_as = 1'b0; m_ac = 3'b010; m_halt = 1'b0; m_ret = 16'h0;
  endtask

  task automatic do_reset();
    imem_ready = 1'b0;
    if (sel_b) rst_b_n = 1'b0; else rst_a_n = 1'b0;
    #2;
    model_reset();
    check_all(3'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    if (sel_b) rst_b_n = 1'b1; else rst_a_n = 1'b1;
  endtask

  task automatic run_instr(input logic [3:0] op, input int stalls);
    logic [5:0] d;
    for (int s = 0; s < stalls; s++) step(1'b0, 4'($urandom), 3'd0, 1'b0, 1'b0);
    step(1'b1, 4'($urandom), 3'd0, 1'b1, 1'b0);
    step(1'($urandom), op, 3'd1, 1'b0, 1'b0);
    d = ref_decode(op);
    if (d[5]) begin
      m_rd = d[4]; m_as = d[3]; m_ac = d[2:0];
      step(1'($urandom), 4'($urandom), 3'd2, 1'b0, 1'b0);
      step(1'($urandom), 4'($urandom), 3'd3, 1'b0, 1'b1);
      m_ret = (m_ret + 16'h1) & cnt_mask();
    end else if (!sel_b) begin
      m_halt = 1'b1;
    end
  endtask

  function automatic logic [3:0] pick_op(input bit allow_illegal);
    if (allow_illegal && $urandom_range(0, 4) == 0) return 4'($urandom_range(8, 15));
    return legal_ops[$urandom_range(0, 5)];
  endfunction

  logic [15:0] wrap_seq [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};

  initial begin
    model_reset();
    @(posedge clock);
    #1;

    // Instance A: 16-bit counter, illegal opcodes halt.
    sel_b = 1'b0;
    do_reset();
    run_instr(4'h0, 0);
    chk("first_add_retired", obs_ret, 16'd1);
    run_instr(4'h7, 0);
    run_instr(4'h4, 0);
    run_instr(4'h1, 3);
    for (int i = 0; i < 40; i++) run_instr(pick_op(1'b0), $urandom_range(0, 2));

    // Asynchronous reset in the middle of WB.
    step(1'b1, 4'($urandom), 3'd0, 1'b1, 1'b0);
    step(1'b1, 4'h3, 3'd1, 1'b0, 1'b0);
    m_rd = 1'b1; m_as = 1'b0; m_ac = 3'b001;
    step(1'b1, 4'($urandom), 3'd2, 1'b0, 1'b0);
    imem_ready = 1'b0;
    #1;
    chk("wb_reg_write_before_reset", 16'(obs_rw), 16'd1);
    rst_a_n = 1'b0;
    #1;
    model_reset();
    check_all(3'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    rst_a_n = 1'b1;
    run_instr(4'h2, 0);
    run_instr(4'h0, 1);

    run_instr(4'hF, 0);
    for (int i = 0; i < 20; i++) step(1'($urandom), 4'($urandom), 3'd4, 1'b0, 1'b0);

    // Instance B: 2-bit counter, illegal opcodes act as NOPs.
    rst_a_n = 1'b0;
    sel_b   = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_instr(4'h0, 0);
      chk("wrap_retired", obs_ret, wrap_seq[i]);
    end
    run_instr(4'h7, 0);
    run_instr(4'hF, 1);
    chk("illegal_nop_alu_src", 16'(obs_as), 16'd1);
    for (int i = 0; i < 40; i++) run_instr(pick_op(1'b1), $urandom_range(0, 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
